stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Central sequencer for the multi-cycle processor core. It drives the rotating one-hot stage enables (fetch, decode/execute, memory, writeback) that gate each pipeline latch, and freezes the rotation while the data memory requests a stall. It also provides halt, single-step and stall-watchdog control for bring-up. It replaces the free-running stage counter and the `clk && !stall` clock gating in the top-level processor with synchronous enables on a single ungated clock.

## Interface
Parameters:
- `NUM_STAGES`, default 4: stages per instruction; must be ≥ 2. Stage `NUM_STAGES-1` is writeback.
- `STALL_TIMEOUT`, default 255: number of consecutive stalled cycles that trips the watchdog; must be ≥ 1.
- `STAGE_WIDTH`, default 2: width of `current_stage`, equal to $clog2(NUM_STAGES).

Ports:
- `clk` input, 1 bit: the single core clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `stall_request` input, 1 bit: level signal from the memory block; while high, the stage rotation holds.
- `halt_request` input, 1 bit: level signal; requests a stop at the next instruction boundary.
- `step_request` input, 1 bit: single-cycle pulse; while halted, executes exactly one instruction.
- `stage_enable` output, `NUM_STAGES` bits: one-hot enable for the active stage; all zero while halted.
- `current_stage` output, `STAGE_WIDTH` bits: index of the active stage.
- `commit` output, 1 bit: combinational; high for the single cycle in which writeback completes. Gates the register-file write and the PC update.
- `halted` output, 1 bit: high in the HALTED state.
- `stall_timeout_error` output, 1 bit: sticky watchdog flag.
- `retired_count` output, 32 bits: number of committed instructions.

## Operation
States are RUN, STEP and HALTED. An "active" state is RUN or STEP.

Reset values:
- State is RUN, `current_stage`=0, `stage_enable`=1 (stage 0 active).
- `halted`=0, `stall_timeout_error`=0, `retired_count`=0.
- Internal stall counter is 0.

Behaviour in an active state:
- On a cycle with `stall_request` low, the stage advances: `current_stage` increments and wraps from `NUM_STAGES-1` to 0. `stage_enable` rotates left with it.
- On a cycle with `stall_request` high, stage and enables hold, and the stall counter increments.
- The stall counter clears on any cycle with `stall_request` low.
- `commit` = active state AND `current_stage == NUM_STAGES-1` AND `!stall_request`.
- On `commit`, `retired_count` increments and wraps modulo 2^32.

Instruction boundary handling (evaluated on `commit`, as the stage wraps to 0):
- RUN with `halt_request` high: go to HALTED.
- STEP: always go to HALTED.
- Otherwise: stay in the current state.

HALTED:
- `stage_enable`=0 and `current_stage`=0; `commit` is never asserted.
- `step_request` high: go to STEP with stage 0 enabled on the next cycle.
- Else if `halt_request` is low: return to RUN at stage 0.
- Else: stay in HALTED.

Rules when events coincide or arrive out of context:
- A stall in the writeback stage delays the boundary; a halt is taken only when the commit actually occurs.
- `step_request` is ignored outside HALTED.
- `halt_request` asserted mid-instruction never truncates the instruction in progress.

Watchdog:
- When the stall counter reaches `STALL_TIMEOUT`, the next edge sets `stall_timeout_error` and forces HALTED.
- The instruction in progress is abandoned without a commit.
- While the error is set, `step_request` and a deasserted `halt_request` are ignored. Only `reset` clears the error.

Reset asserted at any point, including mid-stall or mid-step, returns all state to the reset values asynchronously.

## Timing
- Latency per instruction is `NUM_STAGES` cycles with no stalls; each stalled cycle adds exactly 1.
- `stage_enable`, `current_stage`, `halted`, `stall_timeout_error` and `retired_count` are registered and change only on a rising `clk` edge, or on `reset`.
- `commit` is combinational from registered state and `stall_request`. `stall_request` must settle before the capturing edge.
- Halt latency: `halted` rises on the edge at which the in-flight instruction commits. With no stalls this is at most `NUM_STAGES` cycles after `halt_request` is sampled high.
- Step: the edge that samples `step_request` enters STEP. After `NUM_STAGES` unstalled cycles, `commit` pulses once and `halted` returns high on that edge.
- Watchdog trips after exactly `STALL_TIMEOUT` consecutive stalled cycles. One stall-free cycle fully resets the count.

## Test plan
- Reset, then run 12 cycles with no stall (defaults): `current_stage` sequence is 0,1,2,3 repeated; `commit` is high on cycles 4, 8 and 12; `retired_count`=3.
- Hold `stall_request` high for 3 cycles while in stage 2: the stage stays at 2 for 4 cycles total; `commit` occurs 3 cycles later than unstalled; `retired_count` increments once.
- Raise `halt_request` in stage 1: the instruction finishes and `commit` pulses once; `halted`=1, `stage_enable`=0. Drop `halt_request`: RUN resumes at stage 0 on the next edge.
- While halted, pulse `step_request` twice, 10 cycles apart: each pulse gives exactly one `commit`, and `retired_count` rises by 2 in total. A `step_request` pulse while in RUN has no effect.
- Set `STALL_TIMEOUT`=5 and hold stall high for 5 cycles: `stall_timeout_error`=1 and `halted`=1, with no `commit`. A subsequent `step_request` is ignored. `reset` clears everything.
- Assert `reset` mid-stall in stage 3: outputs go immediately to the reset values; after release, sequencing restarts at stage 0.

Source files
------------

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Central sequencer for the multi-cycle processor core. It produces a rotating
// one-hot set of stage enables (fetch, decode/execute, memory, ..., writeback).
// Every pipeline latch runs on the single ungated core clock and loads only
// when its enable is high. The rotation freezes while the data memory stalls.
//
// The sequencer also provides bring-up controls:
//   - halt at the next instruction boundary,
//   - single-step while halted,
//   - a stall watchdog that abandons a stuck instruction and halts stickily.
//
// Parameters
//   NUM_STAGES    stages per instruction (>= 2); stage NUM_STAGES-1 is writeback
//   STALL_TIMEOUT consecutive stalled cycles that trip the watchdog (>= 1)
//   STAGE_WIDTH   width of current_stage, $clog2(NUM_STAGES)
//
// Ports
//   clk                 in   core clock, rising edge
//   reset               in   asynchronous active-high reset
//   stall_request       in   level, holds the stage rotation while high
//   halt_request        in   level, stop at the next instruction boundary
//   step_request        in   pulse, run one instruction while halted
//   stage_enable        out  one-hot enable of the active stage, zero when halted
//   current_stage       out  index of the active stage
//   commit              out  combinational, writeback completes this cycle
//   halted              out  sequencer is in the HALTED state
//   stall_timeout_error out  sticky watchdog flag, cleared only by reset
//   retired_count       out  committed instruction count, wraps modulo 2^32
//
// Handshake: stall_request is a level qualifier rather than a valid/ready
// pair. The active stage completes on a rising edge only when stall_request
// is low at that edge. commit is the writeback stage's completion strobe, so
// downstream logic must sample it on the same edge.
// -----------------------------------------------------------------------------
module stage_sequencer #(
   parameter int NUM_STAGES    = 4,
   parameter int STALL_TIMEOUT = 255,
   parameter int STAGE_WIDTH   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall_request,
   input  logic                   halt_request,
   input  logic                   step_request,
   output logic [NUM_STAGES-1:0]  stage_enable,
   output logic [STAGE_WIDTH-1:0] current_stage,
   output logic                   commit,
   output logic                   halted,
   output logic                   stall_timeout_error,
   output logic [31:0]            retired_count
);

   // The counter must be able to hold values up to STALL_TIMEOUT-1. The extra
   // head-room keeps the width >= 1 when STALL_TIMEOUT is 1.
   localparam int CNT_WIDTH = $clog2(STALL_TIMEOUT + 1);

   localparam logic [STAGE_WIDTH-1:0] LAST_STAGE  = STAGE_WIDTH'(NUM_STAGES - 1);
   localparam logic [STAGE_WIDTH-1:0] FIRST_STAGE = '0;
   localparam logic [CNT_WIDTH-1:0]   TRIP_COUNT  = CNT_WIDTH'(STALL_TIMEOUT - 1);
   localparam logic [NUM_STAGES-1:0]  FIRST_EN    = {{(NUM_STAGES-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STEP   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Registered state.
   state_t                 state_q;
   logic [STAGE_WIDTH-1:0] stage_q;
   logic [NUM_STAGES-1:0]  enable_q;
   logic [CNT_WIDTH-1:0]   stall_cnt_q;
   logic                   error_q;
   logic [31:0]            retired_q;

   // Next-state values.
   state_t                 state_d;
   logic [STAGE_WIDTH-1:0] stage_d;
   logic [NUM_STAGES-1:0]  enable_d;
   logic [CNT_WIDTH-1:0]   stall_cnt_d;
   logic                   error_d;
   logic [31:0]            retired_d;

   logic active;
   logic commit_now;
   logic trip_now;

   // -------------------------------------------------------------------------
   // Combinational qualifiers
   // -------------------------------------------------------------------------
   assign active     = (state_q != ST_HALTED);
   assign commit_now = active && (stage_q == LAST_STAGE) && !stall_request;

   // The current cycle is the STALL_TIMEOUT-th consecutive stalled one. The
   // counter holds the number of stalled cycles already completed. Commit and
   // trip are mutually exclusive because they need opposite stall levels.
   assign trip_now   = active && stall_request && (stall_cnt_q >= TRIP_COUNT);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         stage_q     <= FIRST_STAGE;
         enable_q    <= FIRST_EN;
         stall_cnt_q <= '0;
         error_q     <= 1'b0;
         retired_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         enable_q    <= enable_d;
         stall_cnt_q <= stall_cnt_d;
         error_q     <= error_d;
         retired_q   <= retired_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      enable_d    = enable_q;
      stall_cnt_d = stall_cnt_q;
      error_d     = error_q;
      retired_d   = retired_q;

      unique case (state_q)
         ST_RUN, ST_STEP: begin
            if (stall_request) begin
               if (trip_now) begin
                  // Abandon the stuck instruction: no commit, and park at
                  // stage 0 with every enable off.
                  error_d     = 1'b1;
                  state_d     = ST_HALTED;
                  stage_d     = FIRST_STAGE;
                  enable_d    = '0;
                  stall_cnt_d = '0;
               end else begin
                  stall_cnt_d = stall_cnt_q + 1'b1;
               end
            end else begin
               stall_cnt_d = '0;
               if (commit_now) begin
                  retired_d = retired_q + 32'd1;
                  stage_d   = FIRST_STAGE;
                  // The boundary is the only place a halt can take effect.
                  // A step always returns to HALTED after its instruction.
                  if ((state_q == ST_STEP) || halt_request) begin
                     state_d  = ST_HALTED;
                     enable_d = '0;
                  end else begin
                     enable_d = FIRST_EN;
                  end
               end else begin
                  stage_d  = stage_q + 1'b1;
                  enable_d = {enable_q[NUM_STAGES-2:0], enable_q[NUM_STAGES-1]};
               end
            end
         end

         ST_HALTED: begin
            stage_d     = FIRST_STAGE;
            enable_d    = '0;
            stall_cnt_d = '0;
            // A tripped watchdog pins the sequencer here until reset.
            if (!error_q) begin
               if (step_request) begin
                  state_d  = ST_STEP;
                  enable_d = FIRST_EN;
               end else if (!halt_request) begin
                  state_d  = ST_RUN;
                  enable_d = FIRST_EN;
               end
            end
         end

         default: begin
            state_d     = ST_RUN;
            stage_d     = FIRST_STAGE;
            enable_d    = FIRST_EN;
            stall_cnt_d = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign stage_enable        = enable_q;
   assign current_stage       = stage_q;
   assign commit              = commit_now;
   assign halted              = (state_q == ST_HALTED);
   assign stall_timeout_error = error_q;
   assign retired_count       = retired_q;

   // -------------------------------------------------------------------------
   // Structural invariants
   // -------------------------------------------------------------------------
   // The enable vector is either all zero (halted) or exactly the bit that
   // current_stage selects.
   a_enable_matches_stage : assert property (@(posedge clk) disable iff (reset)
      (halted && (stage_enable == '0)) ||
      (!halted && (stage_enable == (FIRST_EN << current_stage))));

   // The watchdog flag only sets while halted.
   a_error_implies_halted : assert property (@(posedge clk) disable iff (reset)
      stall_timeout_error |-> halted);

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Directed bench for stage_sequencer with NUM_STAGES=4 and STALL_TIMEOUT=5.
// A behavioural model tracks the mode, the stage index, the retire count and
// the stall run length as plain integers. A compare process checks every
// output against the model on each falling edge. The driver also checks
// hand-computed literals at key points to pin the model itself.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

  localparam int N  = 4;
  localparam int TO = 5;

  logic          clk;
  logic          reset;
  logic          stall_request;
  logic          halt_request;
  logic          step_request;
  logic [N-1:0]  stage_enable;
  logic [1:0]    current_stage;
  logic          commit;
  logic          halted;
  logic          stall_timeout_error;
  logic [31:0]   retired_count;

  int n_cmp;
  int n_err;
  int commit_seen;

  stage_sequencer #(
    .NUM_STAGES(N),
    .STALL_TIMEOUT(TO),
    .STAGE_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall_request(stall_request),
    .halt_request(halt_request),
    .step_request(step_request),
    .stage_enable(stage_enable),
    .current_stage(current_stage),
    .commit(commit),
    .halted(halted),
    .stall_timeout_error(stall_timeout_error),
    .retired_count(retired_count)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // mode: 0 = run, 1 = step, 2 = halted
  int          m_mode;
  int          m_stage;
  int          m_stalls;
  bit          m_err;
  logic [31:0] m_ret;

  function automatic void model_next(
    input  int mode, input int stage, input int stalls, input bit err,
    input  logic [31:0] ret, input bit stall, input bit halt, input bit step,
    output int n_mode, output int n_stage, output int n_stalls, output bit n_err,
    output logic [31:0] n_ret);
    n_mode = mode; n_stage = stage; n_stalls = stalls; n_err = err; n_ret = ret;
    if (mode != 2) begin
      if (stall) begin
        n_stalls = stalls + 1;
        if (n_stalls == TO) begin
          n_err = 1'b1; n_mode = 2; n_stage = 0; n_stalls = 0;
        end
      end else begin
        n_stalls = 0;
        n_stage  = (stage + 1) % N;
        if (stage == N - 1) begin
          n_ret = ret + 32'd1;
          if (mode == 1 || halt) n_mode = 2;
        end
      end
    end else begin
      n_stage = 0;
      if (!err) begin
        if (step) n_mode = 1;
        else if (!halt) n_mode = 0;
      end
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0; m_stage <= 0; m_stalls <= 0; m_err <= 1'b0; m_ret <= 32'd0;
    end else begin
      int nm, ns, nst;
      bit ne;
      logic [31:0] nr;
      model_next(m_mode, m_stage, m_stalls, m_err, m_ret,
                 stall_request, halt_request, step_request, nm, ns, nst, ne, nr);
      m_mode <= nm; m_stage <= ns; m_stalls <= nst; m_err <= ne; m_ret <= nr;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_en;
    bit          exp_commit;
    exp_en     = (m_mode == 2) ? 32'd0 : (32'd1 << m_stage);
    exp_commit = (m_mode != 2) && (m_stage == N - 1) && !stall_request && !reset;
    chk("model_stage",   32'(current_stage),       32'(m_stage));
    chk("model_enable",  32'(stage_enable),        exp_en);
    chk("model_halted",  32'(halted),              32'(m_mode == 2));
    chk("model_error",   32'(stall_timeout_error), 32'(m_err));
    chk("model_retired", retired_count,            m_ret);
    chk("model_commit",  32'(commit),              32'(exp_commit));
    if (commit) commit_seen++;
  end

  // ---------------------------------------------------------------- driver
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0;
  logic [31:0] r0;

  initial begin
    n_cmp = 0; n_err = 0; commit_seen = 0;
    reset = 1'b1; stall_request = 1'b0; halt_request = 1'b0; step_request = 1'b0;
    cyc(2);
    reset = 1'b0;

    // Reset state.
    chk("rst_stage",   32'(current_stage),       32'd0);
    chk("rst_enable",  32'(stage_enable),        32'd1);
    chk("rst_halted",  32'(halted),              32'd0);
    chk("rst_error",   32'(stall_timeout_error), 32'd0);
    chk("rst_retired", retired_count,            32'd0);

    // Free run: 12 cycles give three commits and wrap back to stage 0.
    c0 = commit_seen;
    cyc(12);
    chk("run12_retired", retired_count,          32'd3);
    chk("run12_commits", 32'(commit_seen - c0),  32'd3);
    chk("run12_stage",   32'(current_stage),     32'd0);

    // Three-cycle stall in stage 2.
    cyc(2);
    chk("pre_stall_stage", 32'(current_stage), 32'd2);
    stall_request = 1'b1;
    cyc(3);
    chk("stall_hold_stage", 32'(current_stage), 32'd2);
    chk("stall_hold_en",    32'(stage_enable),  32'd4);
    stall_request = 1'b0;
    cyc(1);
    chk("post_stall_stage", 32'(current_stage), 32'd3);
    cyc(1);
    chk("stall_retired", retired_count, 32'd4);

    // Halt raised in stage 1 completes the instruction, then halts.
    cyc(1);
    halt_request = 1'b1;
    c0 = commit_seen;
    cyc(3);
    chk("halt_halted",  32'(halted),             32'd1);
    chk("halt_enable",  32'(stage_enable),       32'd0);
    chk("halt_commits", 32'(commit_seen - c0),   32'd1);
    chk("halt_retired", retired_count,           32'd5);
    halt_request = 1'b0;
    cyc(1);
    chk("resume_halted", 32'(halted),        32'd0);
    chk("resume_enable", 32'(stage_enable),  32'd1);

    // Step pulse while running has no effect.
    step_request = 1'b1;
    cyc(1);
    step_request = 1'b0;
    chk("run_step_stage", 32'(current_stage), 32'd1);
    halt_request = 1'b1;
    cyc(3);
    chk("halt2_halted", 32'(halted), 32'd1);

    // Two single steps, ten cycles apart.
    r0 = retired_count;
    c0 = commit_seen;
    for (int k = 0; k < 2; k++) begin
      step_request = 1'b1;
      cyc(1);
      step_request = 1'b0;
      chk("step_active", 32'(halted), 32'd0);
      cyc(4);
      chk("step_rehalt", 32'(halted), 32'd1);
      cyc(5);
    end
    chk("step_retired_delta", retired_count - r0,        32'd2);
    chk("step_commits",       32'(commit_seen - c0),     32'd2);

    // Watchdog: five stalled cycles trip it, no commit.
    halt_request = 1'b0;
    cyc(1);
    r0 = retired_count;
    stall_request = 1'b1;
    cyc(4);
    chk("wd_not_yet", 32'(stall_timeout_error), 32'd0);
    cyc(1);
    chk("wd_error",   32'(stall_timeout_error), 32'd1);
    chk("wd_halted",  32'(halted),              32'd1);
    chk("wd_retired", retired_count,            r0);
    stall_request = 1'b0;
    step_request = 1'b1;
    cyc(1);
    step_request = 1'b0;
    cyc(2);
    chk("wd_step_ignored", 32'(halted), 32'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("wd_reset_error",   32'(stall_timeout_error), 32'd0);
    chk("wd_reset_retired", retired_count,            32'd0);
    chk("wd_reset_halted",  32'(halted),              32'd0);

    // Reset asserted mid-stall in stage 3 acts immediately.
    cyc(3);
    chk("pre_rst_stage", 32'(current_stage), 32'd3);
    stall_request = 1'b1;
    cyc(2);
    reset = 1'b1;
    #1;
    chk("async_rst_stage",  32'(current_stage), 32'd0);
    chk("async_rst_enable", 32'(stage_enable),  32'd1);
    stall_request = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(2);
    chk("restart_stage", 32'(current_stage), 32'd2);

    cyc(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
